// File: rtl/tm1640_rx.sv
// Receive-side decoder for the 2-wire TM1640-style display link.
// Oversamples tm_clk/tm_din, detects start/stop/bit events and rebuilds
// the digit image, brightness level and display-on state.
module tm1640_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DIGITS  = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tm_clk,
    input  logic        tm_din,
    output logic [71:0] data_pack,
    output logic [2:0]  level,
    output logic        on,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, SKIP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg, din_sync_reg;
    logic                   clk_prev_reg, din_prev_reg;
    logic                   cs, ds;
    logic                   start_ev, stop_ev, bit_ev;

    state_t      state_reg, state_next;
    logic [2:0]  bitcnt_reg, bitcnt_next;
    logic [6:0]  shift_reg, shift_next;
    logic        mode_reg, mode_next;
    logic [3:0]  addr_reg, addr_next;
    logic [2:0]  level_reg, level_next;
    logic        on_reg, on_next;
    logic [7:0]  byte_data_reg, byte_data_next;
    logic        got_byte_reg, got_byte_next;
    logic        byte_valid_reg, byte_valid_next;
    logic        frame_done_reg, frame_done_next;
    logic        err_reg, err_next;
    logic        wr_en;
    logic [7:0]  byte_full;

    assign cs = clk_sync_reg[SYNC_STAGES-1];
    assign ds = din_sync_reg[SYNC_STAGES-1];

    // A rising link clock always wins: a simultaneous din change is a bit,
    // never a start/stop, because start/stop need the clock high in both samples.
    assign bit_ev   = !clk_prev_reg && cs;
    assign start_ev = clk_prev_reg && cs && din_prev_reg && !ds;
    assign stop_ev  = clk_prev_reg && cs && !din_prev_reg && ds;

    // Byte as it stands once the current sample is shifted in (LSB first).
    assign byte_full = {ds, shift_reg};

    // Input synchronisers plus one-cycle-delayed copies; idle bus is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_reg <= '1;
            din_sync_reg <= '1;
            clk_prev_reg <= 1'b1;
            din_prev_reg <= 1'b1;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], tm_clk};
            din_sync_reg <= {din_sync_reg[SYNC_STAGES-2:0], tm_din};
            clk_prev_reg <= cs;
            din_prev_reg <= ds;
        end
    end

    // Protocol state and decoded-control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            bitcnt_reg     <= '0;
            shift_reg      <= '0;
            mode_reg       <= 1'b0;
            addr_reg       <= '0;
            level_reg      <= '0;
            on_reg         <= 1'b0;
            byte_data_reg  <= '0;
            got_byte_reg   <= 1'b0;
            byte_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bitcnt_reg     <= bitcnt_next;
            shift_reg      <= shift_next;
            mode_reg       <= mode_next;
            addr_reg       <= addr_next;
            level_reg      <= level_next;
            on_reg         <= on_next;
            byte_data_reg  <= byte_data_next;
            got_byte_reg   <= got_byte_next;
            byte_valid_reg <= byte_valid_next;
            frame_done_reg <= frame_done_next;
            err_reg        <= err_next;
        end
    end

    // Next-state decode: frame boundaries first, then bit assembly and byte handling.
    always_comb begin
        state_next      = state_reg;
        bitcnt_next     = bitcnt_reg;
        shift_next      = shift_reg;
        mode_next       = mode_reg;
        addr_next       = addr_reg;
        level_next      = level_reg;
        on_next         = on_reg;
        byte_data_next  = byte_data_reg;
        got_byte_next   = got_byte_reg;
        byte_valid_next = 1'b0;
        frame_done_next = 1'b0;
        err_next        = 1'b0;
        wr_en           = 1'b0;

        if (state_reg == IDLE) begin
            if (start_ev) begin
                state_next    = CMD;
                bitcnt_next   = '0;
                got_byte_next = 1'b0;
            end
        end else if (start_ev) begin
            // Repeated start: abandon the current frame without frame_done.
            err_next      = (bitcnt_reg != 3'd0);
            state_next    = CMD;
            bitcnt_next   = '0;
            got_byte_next = 1'b0;
        end else if (stop_ev) begin
            err_next        = (bitcnt_reg != 3'd0);
            frame_done_next = got_byte_reg;
            state_next      = IDLE;
            bitcnt_next     = '0;
            got_byte_next   = 1'b0;
        end else if (bit_ev) begin
            shift_next  = byte_full[7:1];
            bitcnt_next = bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7) begin
                byte_valid_next = 1'b1;
                byte_data_next  = byte_full;
                got_byte_next   = 1'b1;
                case (state_reg)
                    CMD: begin
                        case (byte_full[7:6])
                            2'b01: begin
                                mode_next  = byte_full[2];
                                state_next = SKIP;
                            end
                            2'b10: begin
                                on_next    = byte_full[3];
                                level_next = byte_full[2:0];
                                state_next = SKIP;
                            end
                            2'b11: begin
                                addr_next  = byte_full[3:0];
                                state_next = DATA;
                            end
                            default: begin
                                err_next   = 1'b1;
                                state_next = SKIP;
                            end
                        endcase
                    end
                    DATA: begin
                        wr_en = 1'b1;
                        if (!mode_reg) begin
                            addr_next = addr_reg + 4'd1;
                        end
                    end
                    SKIP: err_next = 1'b1;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Digit registers; addresses beyond the stored range simply hit no register.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_digit
            if (gi < NUM_DIGITS) begin : g_store
                logic [7:0] digit_reg;
                // Write the completed data byte into this digit when addressed.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        digit_reg <= '0;
                    end else if (wr_en && addr_reg == 4'(gi)) begin
                        digit_reg <= byte_full;
                    end
                end
                assign data_pack[8*gi +: 8] = digit_reg;
            end else begin : g_empty
                assign data_pack[8*gi +: 8] = 8'h00;
            end
        end
    endgenerate

    assign level      = level_reg;
    assign on         = on_reg;
    assign byte_valid = byte_valid_reg;
    assign byte_data  = byte_data_reg;
    assign frame_done = frame_done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_tm1640_rx.sv
// Scoreboard bench for tm1640_rx: the link driver pushes expected byte,
// err and frame_done events; a monitor pops and compares on every pulse.
module tb_tm1640_rx;

    logic        clk;
    logic        rst;
    logic        tm_clk;
    logic        tm_din;
    logic [71:0] data_pack;
    logic [2:0]  level;
    logic        on;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected byte_data per byte_valid, expected byte_valid level per err,
    // expected byte_data per frame_done.
    logic [7:0] byte_q[$];
    logic       err_q[$];
    logic [7:0] done_q[$];

    // Link-side model of the frame in flight.
    int         pending  = 0;
    int         fr_bytes = 0;
    logic [7:0] last_byte = 8'h00;

    localparam time STEP = 40;

    tm1640_rx #(.SYNC_STAGES(2), .NUM_DIGITS(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .tm_clk     (tm_clk),
        .tm_din     (tm_din),
        .data_pack  (data_pack),
        .level      (level),
        .on         (on),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: pulse seen with nothing expected", name);
    endtask

    // Monitor: sample mid-cycle, pop one expectation per pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (byte_valid) begin
                if (byte_q.size() == 0) unexpected("byte_valid");
                else chk("byte_data", {64'h0, byte_data}, {64'h0, byte_q.pop_front()});
            end
            if (err) begin
                if (err_q.size() == 0) unexpected("err");
                else chk("err_with_byte_valid", {71'h0, byte_valid}, {71'h0, err_q.pop_front()});
            end
            if (frame_done) begin
                if (done_q.size() == 0) unexpected("frame_done");
                else chk("frame_done_last_byte", {64'h0, byte_data}, {64'h0, done_q.pop_front()});
            end
        end
    end

    task automatic send_bit(input logic b);
        tm_clk = 1'b0; #(STEP);
        tm_din = b;    #(STEP);
        tm_clk = 1'b1; #(STEP);
    endtask

    task automatic send_start();
        tm_din   = 1'b0; #(STEP);
        pending  = 0;
        fr_bytes = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_err);
        byte_q.push_back(b);
        if (exp_err) err_q.push_back(1'b1);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        fr_bytes++;
        last_byte = b;
    endtask

    task automatic send_partial(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
        pending += n;
    endtask

    // A link left with din high can only reach a stop through one more clock,
    // which the decoder sees as the first bit of an unfinished byte.
    task automatic send_stop();
        if (tm_din) begin
            send_bit(1'b0);
            pending++;
        end
        if (pending % 8 != 0) err_q.push_back(1'b0);
        if (fr_bytes > 0) done_q.push_back(last_byte);
        tm_din   = 1'b1; #(STEP);
        pending  = 0;
        fr_bytes = 0;
    endtask

    task automatic drain(input string tag);
        repeat (10) @(negedge clk);
        chk({tag, "_byte_q_empty"}, 72'(byte_q.size()), 72'h0);
        chk({tag, "_err_q_empty"},  72'(err_q.size()),  72'h0);
        chk({tag, "_done_q_empty"}, 72'(done_q.size()), 72'h0);
    endtask

    initial begin
        rst    = 1'b0;
        tm_clk = 1'b1;
        tm_din = 1'b1;
        #23;
        chk("reset_data_pack", data_pack, 72'h0);
        chk("reset_level_on", {68'h0, level, on}, 72'h0);
        chk("reset_byte_data", {64'h0, byte_data}, 72'h0);
        chk("reset_pulses", {69'h0, byte_valid, frame_done, err}, 72'h0);
        rst = 1'b1;

        // Idle bus: monitor flags any pulse.
        repeat (1000) @(posedge clk);
        #1;
        chk("idle_data_pack", data_pack, 72'h0);

        // Auto-increment, full image.
        send_start(); send_byte(8'h40, 1'b0); send_stop();
        send_start(); send_byte(8'hC0, 1'b0);
        send_byte(8'h3F, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h5B, 1'b0);
        send_byte(8'h4F, 1'b0); send_byte(8'h66, 1'b0); send_byte(8'h6D, 1'b0);
        send_byte(8'h7D, 1'b0); send_byte(8'h07, 1'b0); send_byte(8'h7F, 1'b0);
        send_stop();
        drain("image");
        chk("image_data_pack", data_pack, 72'h7F077D6D664F5B063F);

        // Fixed address: both bytes land on digit 3, second wins.
        send_start(); send_byte(8'h44, 1'b0); send_stop();
        send_start(); send_byte(8'hC3, 1'b0); send_byte(8'h40, 1'b0); send_byte(8'h11, 1'b0); send_stop();
        drain("fixed");
        chk("fixed_data_pack", data_pack, 72'h7F077D6D66115B063F);

        // Display control.
        send_start(); send_byte(8'h8C, 1'b0); send_stop();
        drain("ctrl_8c");
        chk("ctrl_8c_on_level", {68'h0, on, level}, {68'h0, 1'b1, 3'd4});
        send_start(); send_byte(8'h87, 1'b0); send_stop();
        drain("ctrl_87");
        chk("ctrl_87_on_level", {68'h0, on, level}, {68'h0, 1'b0, 3'd7});

        // Back to auto-increment; address 15 is discarded and wraps to 0.
        send_start(); send_byte(8'h40, 1'b0); send_stop();
        send_start(); send_byte(8'hCF, 1'b0); send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_stop();
        drain("wrap");
        chk("wrap_data_pack", data_pack, 72'h7F077D6D66115B06BB);

        // Partial byte then stop: err only.
        send_start(); send_partial(8'b0000_1101, 5); send_stop();
        drain("partial");

        // Extra byte after a data command.
        send_start(); send_byte(8'h40, 1'b0); send_byte(8'h12, 1'b1); send_stop();
        drain("skip");
        chk("skip_data_pack", data_pack, 72'h7F077D6D66115B06BB);

        // Reset in the middle of a byte.
        send_start(); send_partial(8'b0000_0101, 3);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_data_pack", data_pack, 72'h0);
        chk("midrst_level_on", {68'h0, level, on}, 72'h0);
        chk("midrst_byte_data", {64'h0, byte_data}, 72'h0);
        chk("midrst_pulses", {69'h0, byte_valid, frame_done, err}, 72'h0);
        tm_clk  = 1'b1;
        tm_din  = 1'b1;
        pending = 0;
        fr_bytes = 0;
        #(STEP);
        rst = 1'b1;
        #(STEP);

        // Decoding resumes with reset defaults (auto-increment, addr 0).
        send_start(); send_byte(8'hC0, 1'b0); send_byte(8'h55, 1'b0); send_stop();
        drain("resume");
        chk("resume_data_pack", data_pack, 72'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
